lpddr4_init_mrw_sequencer: RTL
==============================

Name: lpddr4_init_mrw_sequencer

Overview:
- Owns the DFI command path from reset until LPDDR4 initialisation completes, then releases it to the multiplexer output.
- Init sequence: RESET_n low, CKE low wait, programmed MRW table, ZQCAL start and latch.
- After init, services single software MRW requests by borrowing the bus through a request/grant handshake with the multiplexer.
- Issues abstract commands to the LPDDR4 CA encoder and drives the bus-select for the DFI source mux.

Parameters:
- NUM_MR, 8, number of entries in the MR table (1..16).
- CNT_W, 16, width of the long init-timer counters.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- init_start  in  1  pulse; starts init from IDLE or DONE, ignored otherwise.
- tINIT1_cfg  in  CNT_W  RESET_n-low cycles.
- tINIT3_cfg  in  CNT_W  CKE-low cycles after RESET_n release.
- tMRW_cfg  in  8  idle cycles after each MRW.
- tZQCAL_cfg  in  CNT_W  cycles from ZQ start to ZQ latch.
- tZQLAT_cfg  in  8  cycles after ZQ latch.
- num_mr_cfg  in  $clog2(NUM_MR+1)  valid table entries.
- mr_table_cfg  in  NUM_MR*14  entry i = {ma[5:0], op[7:0]} at bits [14i+13:14i].
- sw_mrw_req  in  1  level; software MRW request.
- sw_mrw_ma  in  6  software MRW register address.
- sw_mrw_op  in  8  software MRW operand.
- sw_mrw_ack  out  1  one-cycle pulse when the software MRW wait completes.
- bus_req  out  1  request DFI ownership from the multiplexer.
- bus_gnt  in  1  multiplexer idle; bus granted.
- bus_own  out  1  1 = DFI driven by this block, 0 = by the multiplexer.
- cmd_valid  out  1  command valid.
- cmd_ready  in  1  encoder accepts command.
- cmd_type  out  2  0 = MRW, 1 = ZQCAL_START, 2 = ZQCAL_LATCH.
- cmd_ma  out  6  MRW address.
- cmd_op  out  8  MRW operand.
- dfi_reset_n  out  1  DRAM RESET_n.
- dfi_cke  out  1  DRAM CKE.
- init_done  out  1  init complete.
- busy  out  1  state is neither IDLE nor DONE.

Behaviour:
- Reset values (async, rst_n=0):
  - state IDLE; bus_own=1.
  - dfi_reset_n=0, dfi_cke=0, cmd_valid=0, bus_req=0, init_done=0, sw_mrw_ack=0, busy=0.
  - All counters and the table index are 0.
  - Reset mid-sequence aborts immediately to these values.
- Command handshake:
  - The transfer cycle is the cycle with cmd_valid & cmd_ready.
  - cmd_type, ma and op are stable while cmd_valid=1 and ready=0.
  - cmd_valid drops the cycle after the transfer.
  - No combinational path from cmd_ready to cmd_valid.
- Wait counts: a zero cfg value is treated as 1. A wait state lasts exactly max(cfg,1) cycles.
- State machine:
  - IDLE: on init_start, go to RST_LOW. Set bus_own=1, init_done=0, dfi_reset_n=0, dfi_cke=0.
  - RST_LOW: tINIT1 cycles, then dfi_reset_n=1 and go to CKE_WAIT.
  - CKE_WAIT: tINIT3 cycles, then dfi_cke=1 and go to MRW_ISSUE. If num_mr_cfg=0, go to ZQ_START instead.
  - MRW_ISSUE: present table[idx] as MRW. On transfer, go to MRW_WAIT.
  - MRW_WAIT: tMRW cycles, then idx++.
    - If idx (new) == min(num_mr_cfg, NUM_MR), clear idx and go to ZQ_START.
    - Otherwise go to MRW_ISSUE.
    - num_mr_cfg > NUM_MR is clamped.
  - ZQ_START: issue ZQCAL_START. On transfer, go to ZQ_WAIT.
  - ZQ_WAIT: tZQCAL cycles, then ZQ_LATCH.
  - ZQ_LATCH: issue ZQCAL_LATCH. On transfer, go to ZQ_LWAIT.
  - ZQ_LWAIT: tZQLAT cycles, then DONE. On entry to DONE, init_done=1 and bus_own=0 (registered).
  - DONE:
    - init_start takes priority over sw_mrw_req: go to RST_LOW and set bus_own=1 in the same transition.
    - Otherwise, on sw_mrw_req, latch sw_mrw_ma and sw_mrw_op, assert bus_req, go to SW_GNT.
  - SW_GNT: hold bus_req until bus_gnt=1. Then bus_own=1, bus_req=0, go to SW_ISSUE.
  - SW_ISSUE: issue MRW with the latched ma/op. On transfer, go to SW_WAIT.
  - SW_WAIT: tMRW cycles. Then pulse sw_mrw_ack for one cycle, set bus_own=0, go to DONE.
    - A still-high sw_mrw_req in the DONE cycle after the ack starts a new request.
- During init, bus_req stays 0 (ownership is implicit) and sw_mrw_req is ignored.
- init_start is ignored outside IDLE and DONE.
- Config inputs are sampled when each wait counter loads. Changes mid-wait do not affect the running count.
- Counters saturate; no wrap. CNT_W bits cover the full cfg range.

Test Plan:
- Basic init: tINIT1=4, tINIT3=3, num_mr=2 (MR1=0x54, MR2=0x2D), tMRW=2, tZQCAL=5, tZQLAT=2, cmd_ready=1, init_start at cycle 10.
  - dfi_reset_n rises at cycle 15; dfi_cke rises at cycle 18.
  - MRW ma=1,op=0x54 then ma=2,op=0x2D, with 2 idle cycles after each.
  - ZQ start, 5 cycles, ZQ latch, 2 cycles, then init_done=1 and bus_own=0.
- Backpressure: cmd_ready=0 for 7 cycles on the first MRW -> cmd_valid, ma and op held constant; exactly one transfer; sequence shifts by 7 cycles.
- num_mr=0 and all cfg=0 -> every wait lasts 1 cycle; no MRW issued; ZQ start/latch still issued; init_done asserted.
- Software MRW: in DONE, sw_mrw_req with ma=13, op=0xC0; bus_gnt delayed 4 cycles.
  - bus_req is high for those 4 cycles; bus_own rises after the grant.
  - One MRW with ma=13, op=0xC0 is issued; sw_mrw_ack pulses once after tMRW; bus_own returns to 0.
- Reset abort: rst_n low during MRW_WAIT of entry 1 -> all outputs return to reset values asynchronously. A new init_start replays the full sequence from entry 0.
- Simultaneous init_start and sw_mrw_req in DONE -> re-init runs, no bus_req, no sw_mrw_ack. After init_done, the pending sw_mrw_req is serviced.

Source files
------------

// File: rtl/lpddr4_init_mrw_sequencer.sv
// -----------------------------------------------------------------------------
// lpddr4_init_mrw_sequencer
//
// Owns the DFI command path from reset until LPDDR4 initialisation completes.
// The init sequence holds RESET_n low, then holds CKE low, then plays the
// programmed mode-register table as MRW commands and finishes with a ZQ
// calibration start/latch pair. After init the DFI is released to the
// multiplexer (bus_own=0). Single software MRW requests are serviced later by
// borrowing the bus through a bus_req/bus_gnt handshake.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   init_start                    pulse, starts init from IDLE or DONE
//   tINIT1/tINIT3/tZQCAL_cfg      long wait lengths (CNT_W bits, 0 acts as 1)
//   tMRW_cfg, tZQLAT_cfg          short wait lengths (8 bits, 0 acts as 1)
//   num_mr_cfg, mr_table_cfg      MR table size and entries {ma[5:0], op[7:0]}
//   sw_mrw_req/ma/op, sw_mrw_ack  software MRW request and completion pulse
//   bus_req, bus_gnt, bus_own     DFI ownership handshake and mux select
//   cmd_valid/ready/type/ma/op    abstract command to the CA encoder
//   dfi_reset_n, dfi_cke          DRAM RESET_n and CKE
//   init_done, busy               status
// All outputs are registered.
// -----------------------------------------------------------------------------
module lpddr4_init_mrw_sequencer #(
  parameter int NUM_MR = 8,
  parameter int CNT_W  = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           init_start,
  input  logic [CNT_W-1:0]               tINIT1_cfg,
  input  logic [CNT_W-1:0]               tINIT3_cfg,
  input  logic [7:0]                     tMRW_cfg,
  input  logic [CNT_W-1:0]               tZQCAL_cfg,
  input  logic [7:0]                     tZQLAT_cfg,
  input  logic [$clog2(NUM_MR+1)-1:0]    num_mr_cfg,
  input  logic [NUM_MR*14-1:0]           mr_table_cfg,
  input  logic                           sw_mrw_req,
  input  logic [5:0]                     sw_mrw_ma,
  input  logic [7:0]                     sw_mrw_op,
  output logic                           sw_mrw_ack,
  output logic                           bus_req,
  input  logic                           bus_gnt,
  output logic                           bus_own,
  output logic                           cmd_valid,
  input  logic                           cmd_ready,
  output logic [1:0]                     cmd_type,
  output logic [5:0]                     cmd_ma,
  output logic [7:0]                     cmd_op,
  output logic                           dfi_reset_n,
  output logic                           dfi_cke,
  output logic                           init_done,
  output logic                           busy
);

  localparam int MW = $clog2(NUM_MR+1);
  localparam logic [MW-1:0] NUM_MR_L = MW'(NUM_MR);

  localparam logic [1:0] CMD_MRW      = 2'd0;
  localparam logic [1:0] CMD_ZQ_START = 2'd1;
  localparam logic [1:0] CMD_ZQ_LATCH = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_RST_LOW   = 4'd1,
    S_CKE_WAIT  = 4'd2,
    S_MRW_ISSUE = 4'd3,
    S_MRW_WAIT  = 4'd4,
    S_ZQ_START  = 4'd5,
    S_ZQ_WAIT   = 4'd6,
    S_ZQ_LATCH  = 4'd7,
    S_ZQ_LWAIT  = 4'd8,
    S_DONE      = 4'd9,
    S_SW_GNT    = 4'd10,
    S_SW_ISSUE  = 4'd11,
    S_SW_WAIT   = 4'd12
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [MW-1:0]    idx_q;
  logic [MW-1:0]    idx_d;
  logic [MW-1:0]    num_eff_s;
  logic [5:0]       sw_ma_q;
  logic [7:0]       sw_op_q;
  logic             sw_mrw_ack_q;
  logic             bus_req_q;
  logic             bus_own_q;
  logic             cmd_valid_q;
  logic [1:0]       cmd_type_q;
  logic [5:0]       cmd_ma_q;
  logic [7:0]       cmd_op_q;
  logic             dfi_reset_n_q;
  logic             dfi_cke_q;
  logic             init_done_q;
  logic             busy_q;

  // A programmed wait of zero still occupies one cycle.
  function automatic logic [CNT_W-1:0] wait_len(input logic [CNT_W-1:0] cfg);
    if (cfg == '0) begin
      return CNT_W'(1);
    end else begin
      return cfg;
    end
  endfunction

  // Table entry i occupies bits [14i+13:14i] as {ma, op}.
  function automatic logic [13:0] mr_entry(input logic [MW-1:0] idx);
    return mr_table_cfg[14*int'(idx) +: 14];
  endfunction

  // Entry count clamped to the table depth; next table index.
  assign num_eff_s = (int'(num_mr_cfg) > NUM_MR) ? NUM_MR_L : num_mr_cfg;
  assign idx_d     = idx_q + MW'(1);

  // Sequencer FSM with all outputs registered. Wait states load cnt_q with
  // max(cfg,1) on entry and leave when it reaches 1, so a wait of N lasts
  // exactly N cycles; the counter only decrements above 1 and cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      sw_ma_q       <= 6'd0;
      sw_op_q       <= 8'd0;
      sw_mrw_ack_q  <= 1'b0;
      bus_req_q     <= 1'b0;
      bus_own_q     <= 1'b1;
      cmd_valid_q   <= 1'b0;
      cmd_type_q    <= CMD_MRW;
      cmd_ma_q      <= 6'd0;
      cmd_op_q      <= 8'd0;
      dfi_reset_n_q <= 1'b0;
      dfi_cke_q     <= 1'b0;
      init_done_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      sw_mrw_ack_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (init_start) begin
            // Re-init takes priority over a software request in DONE.
            state_q       <= S_RST_LOW;
            cnt_q         <= wait_len(tINIT1_cfg);
            idx_q         <= '0;
            bus_own_q     <= 1'b1;
            bus_req_q     <= 1'b0;
            init_done_q   <= 1'b0;
            dfi_reset_n_q <= 1'b0;
            dfi_cke_q     <= 1'b0;
            busy_q        <= 1'b1;
          end else if ((state_q == S_DONE) && sw_mrw_req) begin
            state_q   <= S_SW_GNT;
            sw_ma_q   <= sw_mrw_ma;
            sw_op_q   <= sw_mrw_op;
            bus_req_q <= 1'b1;
            busy_q    <= 1'b1;
          end else begin
            state_q <= state_q;
          end
        end
        S_RST_LOW: begin
          if (cnt_q <= CNT_W'(1)) begin
            state_q       <= S_CKE_WAIT;
            cnt_q         <= wait_len(tINIT3_cfg);
            dfi_reset_n_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_CKE_WAIT: begin
          if (cnt_q <= CNT_W'(1)) begin
            dfi_cke_q   <= 1'b1;
            cmd_valid_q <= 1'b1;
            idx_q       <= '0;
            if (num_eff_s == '0) begin
              state_q    <= S_ZQ_START;
              cmd_type_q <= CMD_ZQ_START;
              cmd_ma_q   <= 6'd0;
              cmd_op_q   <= 8'd0;
            end else begin
              state_q                <= S_MRW_ISSUE;
              cmd_type_q             <= CMD_MRW;
              {cmd_ma_q, cmd_op_q}   <= mr_entry('0);
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_MRW_ISSUE, S_SW_ISSUE: begin
          if (cmd_ready) begin
            state_q     <= (state_q == S_MRW_ISSUE) ? S_MRW_WAIT : S_SW_WAIT;
            cnt_q       <= wait_len(CNT_W'(tMRW_cfg));
            cmd_valid_q <= 1'b0;
          end else begin
            state_q <= state_q;
          end
        end
        S_MRW_WAIT: begin
          if (cnt_q <= CNT_W'(1)) begin
            cmd_valid_q <= 1'b1;
            // >= keeps the walk bounded if num_mr_cfg shrinks mid-sequence.
            if (idx_d >= num_eff_s) begin
              state_q    <= S_ZQ_START;
              idx_q      <= '0;
              cmd_type_q <= CMD_ZQ_START;
              cmd_ma_q   <= 6'd0;
              cmd_op_q   <= 8'd0;
            end else begin
              state_q              <= S_MRW_ISSUE;
              idx_q                <= idx_d;
              cmd_type_q           <= CMD_MRW;
              {cmd_ma_q, cmd_op_q} <= mr_entry(idx_d);
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_ZQ_START: begin
          if (cmd_ready) begin
            state_q     <= S_ZQ_WAIT;
            cnt_q       <= wait_len(tZQCAL_cfg);
            cmd_valid_q <= 1'b0;
          end else begin
            state_q <= state_q;
          end
        end
        S_ZQ_WAIT: begin
          if (cnt_q <= CNT_W'(1)) begin
            state_q     <= S_ZQ_LATCH;
            cmd_valid_q <= 1'b1;
            cmd_type_q  <= CMD_ZQ_LATCH;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_ZQ_LATCH: begin
          if (cmd_ready) begin
            state_q     <= S_ZQ_LWAIT;
            cnt_q       <= wait_len(CNT_W'(tZQLAT_cfg));
            cmd_valid_q <= 1'b0;
          end else begin
            state_q <= state_q;
          end
        end
        S_ZQ_LWAIT: begin
          if (cnt_q <= CNT_W'(1)) begin
            state_q     <= S_DONE;
            init_done_q <= 1'b1;
            bus_own_q   <= 1'b0;
            busy_q      <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_SW_GNT: begin
          if (bus_gnt) begin
            state_q     <= S_SW_ISSUE;
            bus_own_q   <= 1'b1;
            bus_req_q   <= 1'b0;
            cmd_valid_q <= 1'b1;
            cmd_type_q  <= CMD_MRW;
            cmd_ma_q    <= sw_ma_q;
            cmd_op_q    <= sw_op_q;
          end else begin
            state_q <= state_q;
          end
        end
        S_SW_WAIT: begin
          if (cnt_q <= CNT_W'(1)) begin
            state_q      <= S_DONE;
            sw_mrw_ack_q <= 1'b1;
            bus_own_q    <= 1'b0;
            busy_q       <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q     <= S_IDLE;
          cmd_valid_q <= 1'b0;
          bus_req_q   <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign sw_mrw_ack  = sw_mrw_ack_q;
  assign bus_req     = bus_req_q;
  assign bus_own     = bus_own_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_type    = cmd_type_q;
  assign cmd_ma      = cmd_ma_q;
  assign cmd_op      = cmd_op_q;
  assign dfi_reset_n = dfi_reset_n_q;
  assign dfi_cke     = dfi_cke_q;
  assign init_done   = init_done_q;
  assign busy        = busy_q;

endmodule
